// File: rtl/conv_pkg.sv
// Shared types, default geometry and helpers for the conv output collector.
package conv_pkg;

    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_CH    = 3;
    localparam int unsigned DEF_IMG_W = 8;
    localparam int unsigned DEF_IMG_H = 8;
    localparam int unsigned DEF_K     = 3;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Number of valid output positions for a frame and a square kernel.
    function automatic int unsigned calc_out_n(input int unsigned img_w,
                                               input int unsigned img_h,
                                               input int unsigned k);
        return (img_w - k + 1) * (img_h - k + 1);
    endfunction

endpackage

// File: rtl/conv_sync_fifo.sv
// Synchronous show-ahead FIFO; push and pop may coincide at any occupancy.
module conv_sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            do_pop;
    logic            do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNTW'(DEPTH));
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; reset clears contents so the head reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNTW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_out_collector.sv
// Tracks raster position of incoming samples and captures channel results at
// valid conv output positions into a FIFO drained by a valid/ready stream.
// Optional macro CONV_OUT_RELU_EN clamps negative channel values to zero before push.
module conv_out_collector
    import conv_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned CH    = DEF_CH,
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned K     = DEF_K,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_vld,
    input  logic [CH*DW-1:0]     ans_flat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [CH*DW-1:0]     out_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 ovf,
    output logic [$clog2(calc_out_n(IMG_W, IMG_H, K) + 1)-1:0] out_cnt
);

    localparam int unsigned OUT_N  = calc_out_n(IMG_W, IMG_H, K);
    localparam int unsigned CNT_W  = $clog2(OUT_N + 1);
    localparam int unsigned CW     = $clog2(IMG_W);
    localparam int unsigned RW     = $clog2(IMG_H);
    localparam int unsigned DATA_W = CH * DW;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [DATA_W-1:0] push_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pix_vld;
    logic              col_last;
    logic              row_last;
    logic              cap;
    logic              pop;
    logic              push;
    logic              drop;
    logic              frame_end;
    logic              arm;

    assign pix_vld   = (state_q == RUN) && in_vld;
    assign col_last  = (col_q == CW'(IMG_W - 1));
    assign row_last  = (row_q == RW'(IMG_H - 1));
    assign cap       = pix_vld && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
    assign pop       = out_vld && out_rdy;
    assign push      = cap && (!fifo_full || pop);
    assign drop      = cap && fifo_full && !pop;
    assign frame_end = pix_vld && row_last && col_last;
    assign arm       = (state_q == IDLE) && start;
    assign busy      = (state_q != IDLE);
    assign out_vld   = !fifo_empty;

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (frame_end) state_d = FLUSH;
            FLUSH:   if (fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Raster position, result count, sticky overflow and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            out_cnt    <= '0;
            ovf        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state_q == FLUSH) && fifo_empty;
            if (arm) begin
                col_q   <= '0;
                row_q   <= '0;
                out_cnt <= '0;
                ovf     <= 1'b0;
            end else begin
                if (pix_vld) begin
                    if (col_last) begin
                        col_q <= '0;
                        row_q <= row_q + RW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                if (push) begin
                    out_cnt <= out_cnt + CNT_W'(1);
                end
                if (drop) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // Optional per-channel clamp of negative results; pure wiring otherwise.
    always_comb begin
        push_data = ans_flat;
`ifdef CONV_OUT_RELU_EN
        for (int unsigned c = 0; c < CH; c++) begin
            if (ans_flat[c*DW + DW - 1]) begin
                push_data[c*DW +: DW] = '0;
            end
        end
`endif
    end

    conv_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector: default 8x8/K3 instance plus a 5x4/K2 single-channel instance.
module tb_conv_out_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        a_start, a_in_vld, a_out_rdy, a_out_vld, a_busy, a_frame_done, a_ovf;
    logic [23:0] a_ans, a_out_data;
    logic [5:0]  a_out_cnt;

    logic        b_start, b_in_vld, b_out_rdy, b_out_vld, b_busy, b_frame_done, b_ovf;
    logic [7:0]  b_ans, b_out_data;
    logic [3:0]  b_out_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_a    = 0;
    int fd_b    = 0;

    logic [23:0] exp_a[$];
    logic [7:0]  exp_b[$];

    conv_out_collector u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (a_start),
        .in_vld     (a_in_vld),
        .ans_flat   (a_ans),
        .out_vld    (a_out_vld),
        .out_rdy    (a_out_rdy),
        .out_data   (a_out_data),
        .busy       (a_busy),
        .frame_done (a_frame_done),
        .ovf        (a_ovf),
        .out_cnt    (a_out_cnt)
    );

    conv_out_collector #(
        .DW(8), .CH(1), .IMG_W(5), .IMG_H(4), .K(2), .DEPTH(4)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (b_start),
        .in_vld     (b_in_vld),
        .ans_flat   (b_ans),
        .out_vld    (b_out_vld),
        .out_rdy    (b_out_rdy),
        .out_data   (b_out_data),
        .busy       (b_busy),
        .frame_done (b_frame_done),
        .ovf        (b_ovf),
        .out_cnt    (b_out_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample stream outputs of both instances, then advance one clock.
    task automatic step();
        if (a_out_vld && a_out_rdy) begin
            chk("a_pop_expected", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) chk("a_out_data", 32'(a_out_data), 32'(exp_a.pop_front()));
        end
        if (a_frame_done) begin
            fd_a++;
            chk("a_fd_after_drain", 32'(exp_a.size()), 32'd0);
        end
        if (b_out_vld && b_out_rdy) begin
            chk("b_pop_expected", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) chk("b_out_data", 32'(b_out_data), 32'(exp_b.pop_front()));
        end
        if (b_frame_done) begin
            fd_b++;
            chk("b_fd_after_drain", 32'(exp_b.size()), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy_val(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        return 1'b0;
    endfunction

    // Expected captures for the 8x8/K3 frame: pixels with row>=2 and col>=2.
    task automatic fill_exp_a(input int limit, input bit relu_pix);
        int n = 0;
        for (int p = 0; p < 64; p++) begin
            if ((p / 8) >= 2 && (p % 8) >= 2 && n < limit) begin
                if (relu_pix && p == 18) begin
`ifdef CONV_OUT_RELU_EN
                    exp_a.push_back(24'h000500);
`else
                    exp_a.push_back(24'h8005FB);
`endif
                end else begin
                    exp_a.push_back({3{8'(p)}});
                end
                n++;
            end
        end
    endtask

    task automatic frame_a(input int npix, input int gap, input int rdy_mode, input bit relu_pix);
        a_out_rdy = rdy_val(rdy_mode);
        a_start   = 1'b1;
        step();
        a_start   = 1'b0;
        chk("a_busy_after_start", 32'(a_busy), 32'd1);
        for (int p = 0; p < npix; p++) begin
            for (int g = 0; g < gap; g++) begin
                a_in_vld  = 1'b0;
                a_ans     = 24'hEEEEEE;
                a_out_rdy = rdy_val(rdy_mode);
                step();
            end
            a_in_vld  = 1'b1;
            a_ans     = (relu_pix && p == 18) ? 24'h8005FB : {3{8'(p)}};
            a_out_rdy = rdy_val(rdy_mode);
            step();
        end
        a_in_vld = 1'b0;
    endtask

    task automatic wait_fd_a(input int budget);
        int s = fd_a;
        int n = 0;
        a_out_rdy = 1'b1;
        while (fd_a == s && n < budget) begin
            step();
            n++;
        end
        chk("a_frame_done_seen", 32'(fd_a - s), 32'd1);
        chk("a_busy_idle", 32'(a_busy), 32'd0);
        step();
        step();
        chk("a_frame_done_single", 32'(fd_a - s), 32'd1);
        chk("a_exp_drained", 32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        a_start   = 1'b0; a_in_vld = 1'b0; a_out_rdy = 1'b0; a_ans = '0;
        b_start   = 1'b0; b_in_vld = 1'b0; b_out_rdy = 1'b1; b_ans = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state.
        chk("rst_out_vld",    32'(a_out_vld),    32'd0);
        chk("rst_out_data",   32'(a_out_data),   32'd0);
        chk("rst_busy",       32'(a_busy),       32'd0);
        chk("rst_frame_done", 32'(a_frame_done), 32'd0);
        chk("rst_ovf",        32'(a_ovf),        32'd0);
        chk("rst_out_cnt",    32'(a_out_cnt),    32'd0);
        rst_n = 1'b1;
        step();

        // Full frame, continuous valid, no backpressure.
        fill_exp_a(36, 1'b0);
        frame_a(64, 0, 0, 1'b0);
        wait_fd_a(40);
        chk("t1_out_cnt", 32'(a_out_cnt), 32'd36);
        chk("t1_ovf",     32'(a_ovf),     32'd0);

        // Alternating valid with random ready.
        fill_exp_a(36, 1'b0);
        frame_a(64, 1, 1, 1'b0);
        wait_fd_a(60);
        chk("t2_out_cnt", 32'(a_out_cnt), 32'd36);
        chk("t2_ovf",     32'(a_ovf),     32'd0);

        // Ready held low: FIFO fills with first 8 results, rest dropped.
        fill_exp_a(8, 1'b0);
        frame_a(64, 0, 2, 1'b0);
        chk("t3_ovf",       32'(a_ovf),      32'd1);
        chk("t3_out_cnt",   32'(a_out_cnt),  32'd8);
        chk("t3_busy_hold", 32'(a_busy),     32'd1);
        chk("t3_head_vld",  32'(a_out_vld),  32'd1);
        chk("t3_head_data", 32'(a_out_data), 32'h121212);
        for (int i = 0; i < 5; i++) step();
        chk("t3_no_fd_while_full", 32'(fd_a), 32'd2);
        wait_fd_a(40);
        chk("t3_out_cnt_end", 32'(a_out_cnt), 32'd8);

        // Reset mid-frame after 30 samples with data stuck in the FIFO.
        frame_a(30, 0, 2, 1'b0);
        chk("t4_ovf_pre",  32'(a_ovf),     32'd1);
        chk("t4_vld_pre",  32'(a_out_vld), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t4_out_vld",    32'(a_out_vld),    32'd0);
        chk("t4_out_data",   32'(a_out_data),   32'd0);
        chk("t4_busy",       32'(a_busy),       32'd0);
        chk("t4_frame_done", 32'(a_frame_done), 32'd0);
        chk("t4_ovf",        32'(a_ovf),        32'd0);
        chk("t4_out_cnt",    32'(a_out_cnt),    32'd0);
        step();

        // Fresh frame after reset, with a mixed-sign sample at the first capture point.
        fill_exp_a(36, 1'b1);
        frame_a(64, 0, 0, 1'b1);
        wait_fd_a(40);
        chk("t6_out_cnt", 32'(a_out_cnt), 32'd36);

        // Small geometry; samples before start must be ignored.
        b_in_vld = 1'b1;
        b_ans    = 8'hAA;
        for (int i = 0; i < 3; i++) step();
        chk("t5_idle_vld",  32'(b_out_vld), 32'd0);
        chk("t5_idle_busy", 32'(b_busy),    32'd0);
        b_in_vld = 1'b0;
        b_start  = 1'b1;
        step();
        b_start  = 1'b0;
        for (int p = 6; p < 20; p++) begin
            if ((p % 5) != 0) exp_b.push_back(8'(p));
        end
        for (int p = 0; p < 20; p++) begin
            b_in_vld = 1'b1;
            b_ans    = 8'(p);
            step();
        end
        b_in_vld = 1'b0;
        begin
            int n = 0;
            while (fd_b == 0 && n < 30) begin
                step();
                n++;
            end
        end
        chk("t5_frame_done", 32'(fd_b),           32'd1);
        chk("t5_out_cnt",    32'(b_out_cnt),      32'd12);
        chk("t5_ovf",        32'(b_ovf),          32'd0);
        chk("t5_drained",    32'(exp_b.size()),   32'd0);
        chk("t5_busy",       32'(b_busy),         32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_out_collector.md
Name: conv_out_collector

Overview:
Parametrised successor of the fixed 3-channel conv result capture register. It tracks the raster position of each valid input sample for an IMG_W x IMG_H frame and a K x K kernel, and captures CH channel results only at valid output positions. Captured results are buffered in a small FIFO and drained through a valid/ready stream. It sits between the convolution MAC datapath and the pooling/writeback stage.

Parameters:
DW, 8, bits per channel result
CH, 3, channel count
IMG_W, 8, input frame width in pixels (>= K)
IMG_H, 8, input frame height in pixels (>= K)
K, 3, kernel size; output frame is (IMG_W-K+1) x (IMG_H-K+1)
DEPTH, 8, FIFO depth (power of two, >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse that arms a new frame
in_vld  in  1  datapath sample valid; ans_flat is aligned to the current input pixel
ans_flat  in  CH*DW  channel results, channel c at bits [c*DW +: DW]
out_vld  out  1  head of FIFO valid
out_rdy  in  1  downstream ready
out_data  out  CH*DW  FIFO head, same packing as ans_flat
busy  out  1  high in RUN or FLUSH
frame_done  out  1  one-cycle pulse at end of frame
ovf  out  1  sticky; a capture was dropped because the FIFO was full
out_cnt  out  clog2(OUT_N+1)  results accepted this frame; OUT_N=(IMG_W-K+1)*(IMG_H-K+1)

Behaviour:
- Reset: rst_n sampled on the clk edge only. All outputs are 0: out_vld=0, out_data=0, busy=0, frame_done=0, ovf=0, out_cnt=0. FIFO is empty, col=row=0, and the state is IDLE. A reset mid-frame discards everything, including FIFO contents.
- FSM IDLE -> RUN on start. On entry, col/row, out_cnt and ovf are cleared. start is ignored in RUN and FLUSH.
- RUN:
  - On each in_vld, col increments. At IMG_W-1, col wraps to 0 and row increments.
  - Capture condition: in_vld && row>=K-1 && col>=K-1.
  - When the capture condition holds and the FIFO is not full, or a pop occurs in the same cycle, ans_flat is pushed and out_cnt increments.
  - When the capture condition holds, the FIFO is full and no pop occurs, the data is dropped and ovf is set to 1.
  - in_vld at row=IMG_H-1, col=IMG_W-1 is processed normally, then the FSM moves to FLUSH.
- FLUSH: in_vld is ignored. When the FIFO is empty, frame_done pulses for 1 cycle and the FSM returns to IDLE. An empty FIFO includes a frame with zero captures.
- In IDLE, in_vld is ignored.
- FIFO:
  - Show-ahead: out_data reflects the head whenever out_vld=1. A pop occurs on out_vld && out_rdy.
  - Simultaneous push and pop is legal at any occupancy.
  - Latency: a push at edge N gives out_vld=1 after edge N if the FIFO was empty (1-cycle latency).
  - out_data holds its last value when empty. Its value is don't-care for checking while out_vld=0.
- Gaps in in_vld stall counting only. out_rdy backpressure never stalls counting; backpressure only risks overflow.
- Width rules: col is clog2(IMG_W) bits and row is clog2(IMG_H) bits. Comparisons are unsigned and there is no arithmetic on data.

Optional Feature:
CONV_OUT_RELU_EN
- Defined: each DW-bit channel is treated as two's complement. Negative values (MSB=1) are replaced by 0 before push, per channel independently.
- Undefined: data is stored unmodified. There is no additional latency either way.

Decomposition:
- Package conv_pkg holds:
  - state enum (IDLE, RUN, FLUSH)
  - default DW/CH/IMG_W/IMG_H/K
  - a constant function returning OUT_N for given IMG_W, IMG_H, K
- Sub-module conv_sync_fifo: parametrised width/depth, synchronous FIFO with show-ahead output and full/empty flags, same clk/rst_n.
- The top contains the FSM, position counters, capture logic and the RELU option.

Test Plan:
- Default params, start, 64 in_vld with ans_flat={3{pixel_index[7:0]}}, out_rdy=1 -> 36 outputs in order 18..23, 26..31, ... 58..63. out_cnt=36, ovf=0, one frame_done after last pop, busy=0 after.
- in_vld toggling 1-cycle on/1-cycle off with random out_rdy -> same 36-value sequence, no loss, frame_done after FIFO drains.
- out_rdy=0 for whole frame, DEPTH=8 -> first 8 results (18..23, 26, 27) held, ovf=1, out_cnt=8. FLUSH holds until out_rdy=1 drains 8 values, then frame_done.
- Assert rst_n=0 for 1 cycle after 30 in_vld -> all outputs 0, FIFO empty, IDLE. A following start plus full frame gives the correct 36 outputs.
- IMG_W=5, IMG_H=4, K=2, CH=1 -> 12 outputs, first at pixel index 6, last at 19. in_vld before start is ignored.
- With CONV_OUT_RELU_EN, ans channel values 0xFB/0x05/0x80 at a capture point -> out_data channels 0x00/0x05/0x00. Without the macro -> 0xFB/0x05/0x80.
